// File: rtl/score_keeper.sv
// Score accumulator for the gameplay core: sums per-cycle event points with
// saturation, tracks the session high score, the ghost combo chain and the bonus life.
module score_keeper #(
  parameter int unsigned SCORE_WIDTH     = 16,
  parameter int unsigned SCORE_MAX       = 9999,
  parameter int unsigned PELLET_PTS      = 10,
  parameter int unsigned POWER_PTS       = 50,
  parameter int unsigned GHOST_BASE_PTS  = 200,
  parameter int unsigned BONUS_THRESHOLD = 5000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   active,
  input  logic                   pellet_eaten,
  input  logic                   power_eaten,
  input  logic                   ghost_eaten,
  input  logic                   fright_end,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SCORE_WIDTH-1:0] high_score,
  output logic [1:0]             ghost_combo,
  output logic                   bonus_life
);

  localparam logic [SCORE_WIDTH-1:0] MaxW    = SCORE_WIDTH'(SCORE_MAX);
  localparam logic [SCORE_WIDTH-1:0] PelletW = SCORE_WIDTH'(PELLET_PTS);
  localparam logic [SCORE_WIDTH-1:0] PowerW  = SCORE_WIDTH'(POWER_PTS);
  localparam logic [SCORE_WIDTH-1:0] GhostW  = SCORE_WIDTH'(GHOST_BASE_PTS);
  localparam logic [SCORE_WIDTH-1:0] BonusW  = SCORE_WIDTH'(BONUS_THRESHOLD);

  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [SCORE_WIDTH-1:0] high_q;
  logic [1:0]             combo_q, combo_d;
  logic                   bonus_life_q;
  logic                   bonus_given_q;
  logic                   bonus_d;
  logic [SCORE_WIDTH-1:0] inc;
  logic [SCORE_WIDTH-1:0] sum;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    inc = '0;
    if (pellet_eaten) inc = inc + PelletW;
    if (power_eaten)  inc = inc + PowerW;
    // Ghost is scored at the pre-update combo, even when power clears it.
    if (ghost_eaten)  inc = inc + (GhostW << combo_q);

    // Worst case 9999 + 1660 fits in 16 bits, so the compare below is exact.
    sum     = score_q + inc;
    score_d = (sum > MaxW) ? MaxW : sum;

    combo_d = combo_q;
    if (power_eaten || fright_end) begin
      combo_d = 2'd0;
    end else if (ghost_eaten && combo_q != 2'd3) begin
      combo_d = combo_q + 2'd1;
    end

    bonus_d = !bonus_given_q && (score_d >= BonusW);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q       <= '0;
      high_q        <= '0;
      combo_q       <= 2'd0;
      bonus_life_q  <= 1'b0;
      bonus_given_q <= 1'b0;
    end else begin
      bonus_life_q <= 1'b0;
      if (score_q > high_q) high_q <= score_q;

      if (new_game) begin
        score_q       <= '0;
        combo_q       <= 2'd0;
        bonus_given_q <= 1'b0;
      end else if (active) begin
        score_q <= score_d;
        combo_q <= combo_d;
        if (bonus_d) begin
          bonus_life_q  <= 1'b1;
          bonus_given_q <= 1'b1;
        end
      end
    end
  end

  assign score       = score_q;
  assign high_score  = high_q;
  assign ghost_combo = combo_q;
  assign bonus_life  = bonus_life_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random strobes,
// all compared against a behavioural score model.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst, new_game, active;
  logic        pellet_eaten, power_eaten, ghost_eaten, fright_end;
  logic [15:0] score, high_score;
  logic [1:0]  ghost_combo;
  logic        bonus_life;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_score, m_high, m_combo, m_bonus, m_given;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk          (clk),
    .rst          (rst),
    .new_game     (new_game),
    .active       (active),
    .pellet_eaten (pellet_eaten),
    .power_eaten  (power_eaten),
    .ghost_eaten  (ghost_eaten),
    .fright_end   (fright_end),
    .score        (score),
    .high_score   (high_score),
    .ghost_combo  (ghost_combo),
    .bonus_life   (bonus_life)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_score"}, {16'd0, score}, 32'(m_score));
    check({tag, "_high"},  {16'd0, high_score}, 32'(m_high));
    check({tag, "_combo"}, {30'd0, ghost_combo}, 32'(m_combo));
    check({tag, "_bonus"}, {31'd0, bonus_life}, 32'(m_bonus));
  endtask

  task automatic do_reset();
    rst = 1'b1; new_game = 1'b0; active = 1'b0;
    pellet_eaten = 1'b0; power_eaten = 1'b0; ghost_eaten = 1'b0; fright_end = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_score = 0; m_high = 0; m_combo = 0; m_bonus = 0; m_given = 0;
  endtask

  // One clock of stimulus; the model applies the scoring rules directly.
  task automatic step(input string tag, input bit act, input bit p, input bit pw,
                      input bit g, input bit fe, input bit ng);
    int inc;
    active = act; pellet_eaten = p; power_eaten = pw;
    ghost_eaten = g; fright_end = fe; new_game = ng;
    @(posedge clk); #1;
    if (m_score > m_high) m_high = m_score;
    m_bonus = 0;
    if (ng) begin
      m_score = 0; m_combo = 0; m_given = 0;
    end else if (act) begin
      inc = (p ? 10 : 0) + (pw ? 50 : 0) + (g ? 200 * (2 ** m_combo) : 0);
      m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
      if (pw || fe) m_combo = 0;
      else if (g) m_combo = (m_combo < 3) ? m_combo + 1 : 3;
      if (!m_given && m_score >= 5000) begin
        m_bonus = 1; m_given = 1;
      end
    end
    check_model(tag);
  endtask

  initial begin
    int saved_score, saved_combo;

    // Reset state
    do_reset();
    check_model("reset");

    // 1: three separate pellets, high score lags by one cycle
    step("t1", 1, 1, 0, 0, 0, 0); check("t1_s10", {16'd0, score}, 32'd10);
    step("t1", 1, 0, 0, 0, 0, 0);
    step("t1", 1, 1, 0, 0, 0, 0); check("t1_s20", {16'd0, score}, 32'd20);
    step("t1", 1, 0, 0, 0, 0, 0);
    step("t1", 1, 1, 0, 0, 0, 0); check("t1_s30", {16'd0, score}, 32'd30);
    check("t1_high_lag", {16'd0, high_score}, 32'd20);
    step("t1", 1, 0, 0, 0, 0, 0); check("t1_high30", {16'd0, high_score}, 32'd30);

    // 2: power then a ghost chain, then fright expiry
    step("t2_ng", 1, 0, 0, 0, 0, 1);
    step("t2_pw", 1, 0, 1, 0, 0, 0); check("t2_s50", {16'd0, score}, 32'd50);
    step("t2_g", 1, 0, 0, 1, 0, 0);  check("t2_s250", {16'd0, score}, 32'd250);
    step("t2_g", 1, 0, 0, 1, 0, 0);  check("t2_s650", {16'd0, score}, 32'd650);
    step("t2_g", 1, 0, 0, 1, 0, 0);  check("t2_s1450", {16'd0, score}, 32'd1450);
    check("t2_combo3", {30'd0, ghost_combo}, 32'd3);
    step("t2_g", 1, 0, 0, 1, 0, 0);  check("t2_s3050", {16'd0, score}, 32'd3050);
    step("t2_g", 1, 0, 0, 1, 0, 0);  check("t2_s4650", {16'd0, score}, 32'd4650);
    check("t2_combo_sat", {30'd0, ghost_combo}, 32'd3);
    step("t2_fe", 1, 0, 0, 0, 1, 0); check("t2_combo0", {30'd0, ghost_combo}, 32'd0);

    // 3: climb to 9990, then saturate at 9999
    step("t3_pw", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t3_g", 1, 0, 0, 1, 0, 0);
    while (m_score < 9990) step("t3_p", 1, 1, 0, 0, 0, 0);
    check("t3_s9990", {16'd0, score}, 32'd9990);
    step("t3_g", 1, 0, 0, 1, 0, 0); check("t3_sat", {16'd0, score}, 32'd9999);
    for (int i = 0; i < 3; i++) step("t3_p", 1, 1, 0, 0, 0, 0);
    check("t3_hold_sat", {16'd0, score}, 32'd9999);

    // 4: combined strobes jump past the bonus threshold
    step("t4_ng", 1, 0, 0, 0, 0, 1);
    step("t4_pw", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("t4_g", 1, 0, 0, 1, 0, 0);
    while (m_score < 4990) step("t4_p", 1, 1, 0, 0, 0, 0);
    check("t4_s4990", {16'd0, score}, 32'd4990);
    step("t4_all", 1, 1, 1, 1, 0, 0);
    check("t4_s6650", {16'd0, score}, 32'd6650);
    check("t4_bonus", {31'd0, bonus_life}, 32'd1);
    check("t4_combo0", {30'd0, ghost_combo}, 32'd0);
    step("t4_p", 1, 1, 0, 0, 0, 0); check("t4_one_shot", {31'd0, bonus_life}, 32'd0);
    for (int i = 0; i < 4; i++) step("t4_g", 1, 0, 0, 1, 0, 0);
    step("t4_ng2", 1, 0, 0, 0, 0, 1);
    step("t4_pw2", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("t4_g2", 1, 0, 0, 1, 0, 0);
    check("t4_s6250", {16'd0, score}, 32'd6250);
    step("t4_p2", 1, 1, 0, 0, 0, 0);

    // 5: inactive strobes are ignored; new_game discards events, keeps high
    step("t5_pw", 1, 0, 1, 0, 0, 0);
    step("t5_g", 1, 0, 0, 1, 0, 0);
    saved_score = m_score; saved_combo = m_combo;
    step("t5_idle", 0, 1, 1, 1, 1, 0);
    check("t5_hold_score", {16'd0, score}, 32'(saved_score));
    check("t5_hold_combo", {30'd0, ghost_combo}, 32'(saved_combo));
    step("t5_ng", 1, 1, 0, 0, 0, 1);
    check("t5_ng_score", {16'd0, score}, 32'd0);
    check("t5_ng_high", {16'd0, high_score}, 32'd9999);

    // Random strobes against the model
    for (int i = 0; i < 600; i++) begin
      bit act, p, pw, g, fe, ng;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        check_model("rnd_rst");
      end
      act = ($urandom_range(0, 9) != 0);
      p   = ($urandom_range(0, 1) == 1);
      pw  = ($urandom_range(0, 7) == 0);
      g   = ($urandom_range(0, 2) == 0);
      fe  = ($urandom_range(0, 11) == 0);
      ng  = ($urandom_range(0, 49) == 0);
      step("rnd", act, p, pw, g, fe, ng);
    end

    // 6: reset mid-game clears everything including high score
    do_reset();
    for (int i = 0; i < 200; i++) step("t6_p", 1, 1, 0, 0, 0, 0);
    step("t6_idle", 1, 0, 0, 0, 0, 0);
    check("t6_high2000", {16'd0, high_score}, 32'd2000);
    step("t6_ng", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 123; i++) step("t6_p", 1, 1, 0, 0, 0, 0);
    check("t6_s1230", {16'd0, score}, 32'd1230);
    do_reset();
    check("t6_rst_score", {16'd0, score}, 32'd0);
    check("t6_rst_high", {16'd0, high_score}, 32'd0);
    check("t6_rst_combo", {30'd0, ghost_combo}, 32'd0);
    check("t6_rst_bonus", {31'd0, bonus_life}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
